spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), LSB first, one word per svalid/sready handshake.
// The received word is held on rword/ovalid until the consumer takes it with oready.
module spi_controller #(
  parameter int WORD_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  sck,
  output logic                  ssn,
  output logic                  mosi,
  input  logic                  miso,
  input  logic [WORD_WIDTH-1:0] sword,
  input  logic                  svalid,
  output logic                  sready,
  output logic [WORD_WIDTH-1:0] rword,
  output logic                  ovalid,
  input  logic                  oready
);

  localparam int CW = $clog2(WORD_WIDTH) + 1;
  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]         LAST_BIT  = CW'(WORD_WIDTH - 1);
  localparam logic [PW-1:0]         PHASE_END = PW'(CLK_DIV - 1);
  localparam logic [WORD_WIDTH-1:0] BIT0      = WORD_WIDTH'(1'b1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    TRAIL  = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [PW-1:0]         phase_r, phase_s;
  logic [CW-1:0]         count_r, count_s;
  logic [WORD_WIDTH-1:0] word_r, word_s;
  logic [WORD_WIDTH-1:0] rbuf_r, rbuf_s;
  logic [WORD_WIDTH-1:0] rword_r, rword_s;
  logic                  sck_r, sck_s;
  logic                  ssn_r, ssn_s;
  logic                  mosi_r, mosi_s;
  logic                  ovalid_r, ovalid_s;
  logic                  phase_end_s;
  logic [CW-1:0]         count_inc_s;
  logic                  next_bit_s;
  logic [WORD_WIDTH-1:0] rbuf_upd_s;

  assign phase_end_s = (phase_r == PHASE_END);
  assign count_inc_s = count_r + CW'(1'b1);
  assign next_bit_s  = |(word_r & (BIT0 << count_inc_s));
  // miso lands in the bit slot of the current count, other bits untouched
  assign rbuf_upd_s  = (rbuf_r & ~(BIT0 << count_r)) | (WORD_WIDTH'(miso) << count_r);

  assign sready = (state_r == IDLE) && !ovalid_r;
  assign sck    = sck_r;
  assign ssn    = ssn_r;
  assign mosi   = mosi_r;
  assign rword  = rword_r;
  assign ovalid = ovalid_r;

  // Next-state and next-datapath logic; every state except IDLE lasts CLK_DIV cycles.
  always_comb begin
    state_s  = state_r;
    phase_s  = phase_r;
    count_s  = count_r;
    word_s   = word_r;
    rbuf_s   = rbuf_r;
    rword_s  = rword_r;
    sck_s    = sck_r;
    ssn_s    = ssn_r;
    mosi_s   = mosi_r;
    ovalid_s = ovalid_r;
    case (state_r)
      IDLE: begin
        phase_s = '0;
        if (ovalid_r && oready) begin
          ovalid_s = 1'b0;
        end else if (svalid && sready) begin
          word_s  = sword;
          ssn_s   = 1'b0;
          mosi_s  = sword[0];
          count_s = '0;
          state_s = LEAD;
        end else begin
          state_s = IDLE;
        end
      end
      LEAD, SCK_LO: begin
        if (phase_end_s) begin
          phase_s = '0;
          sck_s   = 1'b1;
          state_s = SCK_HI;
        end else begin
          phase_s = phase_r + PW'(1'b1);
        end
      end
      SCK_HI: begin
        if (phase_end_s) begin
          phase_s = '0;
          sck_s   = 1'b0;
          rbuf_s  = rbuf_upd_s;
          if (count_r == LAST_BIT) begin
            state_s = TRAIL;
          end else begin
            count_s = count_inc_s;
            mosi_s  = next_bit_s;
            state_s = SCK_LO;
          end
        end else begin
          phase_s = phase_r + PW'(1'b1);
        end
      end
      TRAIL: begin
        if (phase_end_s) begin
          phase_s  = '0;
          ssn_s    = 1'b1;
          rword_s  = rbuf_r;
          ovalid_s = 1'b1;
          mosi_s   = 1'b0;
          state_s  = IDLE;
        end else begin
          phase_s = phase_r + PW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        phase_s = '0;
        sck_s   = 1'b0;
        ssn_s   = 1'b1;
        mosi_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      phase_r  <= '0;
      count_r  <= '0;
      word_r   <= '0;
      rbuf_r   <= '0;
      rword_r  <= '0;
      sck_r    <= 1'b0;
      ssn_r    <= 1'b1;
      mosi_r   <= 1'b0;
      ovalid_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      phase_r  <= phase_s;
      count_r  <= count_s;
      word_r   <= word_s;
      rbuf_r   <= rbuf_s;
      rword_r  <= rword_s;
      sck_r    <= sck_s;
      ssn_r    <= ssn_s;
      mosi_r   <= mosi_s;
      ovalid_r <= ovalid_s;
    end
  end

endmodule
